gearbox_rx_param: RTL and testbench
===================================

GEARBOX_RX_PARAM -- requirements
Module: gearbox_rx_param

Interface
REQ-001 SHALL have parameter PMA_W, default 64, meaning PMA input word width in bits; legal range 8..64.
REQ-002 SHALL have parameter HEAD_W, default 2, meaning sync header width.
REQ-003 SHALL have parameter DATA_W, default 64, meaning block payload width; block width B = HEAD_W + DATA_W (66 by default).
REQ-004 SHALL have port clk, input, 1, meaning single clock for all logic.
REQ-005 SHALL have port nreset, input, 1, meaning reset; it is asynchronous and active-low.
REQ-006 SHALL have port lock_v_i, input, 1, meaning PMA lock; data_i is accepted only when it is high.
REQ-007 SHALL have port data_i, input, PMA_W, meaning received bits; bit 0 is the earliest on the wire.
REQ-008 SHALL have port slip_v_i, input, 1, meaning a request from block sync to discard one bit.
REQ-009 SHALL have port valid_o, output, 1, meaning head_o/data_o hold a new block this cycle.
REQ-010 SHALL have port head_o, output, HEAD_W, meaning block header; head_o[0] is the earliest bit.
REQ-011 SHALL have port data_o, output, DATA_W, meaning block payload following the header, LSB earliest.

Function
REQ-012 SHALL hold an accumulator of at least B+PMA_W-1 bits and a fill counter of width clog2(B+PMA_W); the oldest bit is at position 0.
REQ-013 SHALL, on each edge with lock_v_i=1, append data_i above the current fill, so the new fill is fill+PMA_W.
REQ-014 SHALL, on the same edge, apply slip_v_i=1 after the append and before extraction: drop the oldest bit and decrement the fill by 1.
REQ-015 SHALL, on the same edge, extract when the post-slip fill is >= B:
  - load the oldest B bits into the output register as {data_o, head_o};
  - set valid_o=1;
  - shift out B bits and reduce the fill by B.
REQ-016 SHALL, on any edge where extraction does not occur, drive valid_o=0; head_o/data_o SHALL hold their last value.
REQ-017 SHALL have a latency of one cycle: a block completed by the data_i word sampled at edge N appears with valid_o at the output after edge N.
REQ-018 SHALL produce at most one block per cycle; because PMA_W <= 64 < B, the fill before append stays below B and the accumulator never overflows.
REQ-019 SHALL, in steady lock, produce exactly floor(k*PMA_W/B) blocks for k input words with no slips, with no loss and no duplication.
REQ-020 SHALL treat each slip_v_i pulse as exactly one bit dropped; slip asserted on consecutive cycles SHALL drop one bit per cycle.
REQ-021 SHALL, on an edge with lock_v_i=0:
  - clear the fill to 0;
  - drive valid_o=0;
  - ignore data_i and slip_v_i;
  - leave head_o/data_o unchanged.
REQ-022 SHALL, on the first lock_v_i=1 edge after a lock loss, behave exactly as from reset.
REQ-023 SHALL, when slip_v_i and extraction coincide, form the extracted block from the post-slip bit stream.

Reset
REQ-024 SHALL, on nreset=0, immediately (asynchronously) drive fill=0, valid_o=0, head_o=0 and data_o=0, regardless of clk.
REQ-025 SHALL clear accumulator contents on reset, or treat them as don't-care, with the fill=0 guarantee ensuring no stale bits are output.
REQ-026 SHALL, after reset deasserts, take the first data_i on the next rising clk edge with lock_v_i=1.

Verification
REQ-027 PMA_W=64, lock high, no slip, 33 consecutive words -> valid_o first high after the 2nd edge; 32 blocks total; valid_o low on exactly one cycle of every 33 in steady state.
REQ-028 PMA_W=32, incrementing bit pattern, 33 words -> 16 blocks; blocks match the serial stream split every 66 bits, with head_o[0] equal to stream bit 66*n.
REQ-029 PMA_W=64, stream of repeated blocks with header 2'b01, one slip_v_i pulse -> subsequent blocks equal the stream offset by 1 bit; after 66 total slips, alignment returns to the original block boundary minus one block.
REQ-030 PMA_W=16, lock_v_i dropped for 1 cycle mid-block (fill=40) -> valid_o low next cycle; the first block after relock needs 5 words (80 >= 66), with no old bits present.
REQ-031 nreset asserted between clock edges with valid_o=1 -> valid_o, head_o and data_o are 0 before the next edge; the restart matches REQ-027.
REQ-032 PMA_W=64, slip on the same edge as extraction (fill 128->127) -> the block contains stream bits 1..66 and the fill becomes 61.

Source files
------------

// File: rtl/gearbox_rx_param.sv
// gearbox_rx_param: PMA-word to block receive gearbox.
// Collects PMA_W-bit words into a bit accumulator with the oldest bit at
// position 0. It honours single-bit slip requests from block sync and emits
// one (HEAD_W + DATA_W)-bit block whenever enough bits are held.
module gearbox_rx_param #(
    parameter int PMA_W  = 64,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              lock_v_i,
    input  logic [PMA_W-1:0]  data_i,
    input  logic              slip_v_i,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int B      = HEAD_W + DATA_W;
    // The fill before an append is always below B, so this width is enough.
    localparam int ACC_W  = B + PMA_W - 1;
    localparam int FILL_W = $clog2(B + PMA_W);

    localparam logic [FILL_W-1:0] B_F   = FILL_W'(B);
    localparam logic [FILL_W-1:0] PMA_F = FILL_W'(PMA_W);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_app;
    logic [ACC_W-1:0]  acc_slip;
    logic [ACC_W-1:0]  acc_nxt;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_app;
    logic [FILL_W-1:0] fill_slip;
    logic [FILL_W-1:0] fill_nxt;
    logic              extract;

    // Append, then slip, then extract; each stage feeds the next.
    // Bits above the fill are kept zero, so an OR is enough to append.
    always_comb begin
        acc_app   = acc_q | (ACC_W'(data_i) << fill_q);
        fill_app  = fill_q + PMA_F;
        acc_slip  = acc_app;
        fill_slip = fill_app;
        if (slip_v_i) begin
            acc_slip  = acc_app >> 1;
            fill_slip = fill_app - FILL_W'(1);
        end
        extract  = (fill_slip >= B_F);
        acc_nxt  = acc_slip;
        fill_nxt = fill_slip;
        if (extract) begin
            acc_nxt  = acc_slip >> B;
            fill_nxt = fill_slip - B_F;
        end
    end

    // Accumulator, fill and output registers. Losing lock empties the accumulator.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q   <= '0;
            fill_q  <= '0;
            valid_o <= 1'b0;
            head_o  <= '0;
            data_o  <= '0;
        end else if (!lock_v_i) begin
            acc_q   <= '0;
            fill_q  <= '0;
            valid_o <= 1'b0;
        end else begin
            acc_q   <= acc_nxt;
            fill_q  <= fill_nxt;
            valid_o <= extract;
            if (extract) begin
                {data_o, head_o} <= acc_slip[B-1:0];
            end
        end
    end

endmodule

// File: tb/tb_gearbox_rx_param.sv
// tb_gearbox_rx_param: three gearbox instances (PMA_W = 64, 32, 16) are
// checked against a serial bit-queue reference model.
module tb_gearbox_rx_param;

    logic        clk = 1'b0;
    logic        nreset;
    logic        lk [3];
    logic        sl [3];
    logic [63:0] dw [3];
    logic        v  [3];
    logic [1:0]  hd [3];
    logic [63:0] dd [3];

    int checks   = 0;
    int failures = 0;

    // Reference model state: the pending serial bit stream of each instance.
    bit          mq [3][$];
    logic        ev [3];
    logic [65:0] eb [3];

    always #5 clk = ~clk;

    gearbox_rx_param #(.PMA_W(64), .HEAD_W(2), .DATA_W(64)) u64 (
        .clk(clk), .nreset(nreset), .lock_v_i(lk[0]), .data_i(dw[0][63:0]),
        .slip_v_i(sl[0]), .valid_o(v[0]), .head_o(hd[0]), .data_o(dd[0]));
    gearbox_rx_param #(.PMA_W(32), .HEAD_W(2), .DATA_W(64)) u32 (
        .clk(clk), .nreset(nreset), .lock_v_i(lk[1]), .data_i(dw[1][31:0]),
        .slip_v_i(sl[1]), .valid_o(v[1]), .head_o(hd[1]), .data_o(dd[1]));
    gearbox_rx_param #(.PMA_W(16), .HEAD_W(2), .DATA_W(64)) u16 (
        .clk(clk), .nreset(nreset), .lock_v_i(lk[2]), .data_i(dw[2][15:0]),
        .slip_v_i(sl[2]), .valid_o(v[2]), .head_o(hd[2]), .data_o(dd[2]));

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            ev[i] = 1'b0;
            eb[i] = '0;
        end
    endtask

    // One clock edge of the serial model: append, slip, take B bits.
    task automatic model_edge(input int i);
        int w;
        bit dummy;
        w = (i == 0) ? 64 : ((i == 1) ? 32 : 16);
        if (!lk[i]) begin
            mq[i].delete();
            ev[i] = 1'b0;
        end else begin
            for (int j = 0; j < w; j++) mq[i].push_back(dw[i][j]);
            if (sl[i]) dummy = mq[i].pop_front();
            if (mq[i].size() >= 66) begin
                for (int j = 0; j < 66; j++) eb[i][j] = mq[i].pop_front();
                ev[i] = 1'b1;
            end else begin
                ev[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk_int($sformatf("%s valid[%0d]", tag, i), int'(v[i]), int'(ev[i]));
            chk_vec($sformatf("%s block[%0d]", tag, i), {dd[i], hd[i]}, eb[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!nreset) model_reset();
        else for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        check_all("step");
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            lk[i] = 1'b0;
            sl[i] = 1'b0;
        end
    endtask

    // 64-bit lane, lock held, no slip, 33 random words.
    task automatic run_027(input string tag);
        int first;
        int cnt;
        first = -1;
        cnt = 0;
        lk[0] = 1'b1;
        sl[0] = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            dw[0] = {$urandom, $urandom};
            step();
            if (v[0] === 1'b1) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        lk[0] = 1'b0;
        step();
        chk_int({tag, " first_valid_edge"}, first, 2);
        chk_int({tag, " block_count"}, cnt, 32);
    endtask

    logic [65:0]  pat;
    logic [65:0]  rot1;
    int           sidx;
    logic [79:0]  cat80;
    logic [191:0] cat192;
    logic [63:0]  w0;
    logic [63:0]  w1;
    logic [63:0]  w2;
    int           cnt;

    function automatic logic [63:0] pat_word(input logic [65:0] p, input int m);
        logic [63:0] w;
        for (int j = 0; j < 64; j++) w[j] = p[(m + j) % 66];
        return w;
    endfunction

    initial begin
        nreset = 1'b0;
        idle_all();
        for (int i = 0; i < 3; i++) dw[i] = '0;
        model_reset();
        #1;
        check_all("reset");
        step();
        step();
        #3 nreset = 1'b1;

        // Lock, continuous words, no slip.
        run_027("r027");

        // 32-bit lane, incrementing word pattern.
        cnt = 0;
        lk[1] = 1'b1;
        for (int k = 0; k < 33; k++) begin
            dw[1] = {32'd0, 32'(k)};
            step();
            if (v[1] === 1'b1) cnt++;
        end
        lk[1] = 1'b0;
        step();
        chk_int("r028 block_count", cnt, 16);

        // Periodic block stream with header 2'b01, then slips.
        pat  = {$urandom, $urandom, 2'b01};
        rot1 = {pat[0], pat[65:1]};
        sidx = 0;
        lk[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dw[0] = pat_word(pat, sidx);
            sidx += 64;
            step();
            if (v[0] === 1'b1) chk_vec("r029 aligned", {dd[0], hd[0]}, pat);
        end
        sl[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            dw[0] = pat_word(pat, sidx);
            sidx += 64;
            step();
            sl[0] = 1'b0;
            if (v[0] === 1'b1) chk_vec("r029 slip1", {dd[0], hd[0]}, rot1);
        end
        sl[0] = 1'b1;
        for (int k = 0; k < 65; k++) begin
            dw[0] = pat_word(pat, sidx);
            sidx += 64;
            step();
        end
        sl[0] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            dw[0] = pat_word(pat, sidx);
            sidx += 64;
            step();
            if (v[0] === 1'b1) begin
                cnt++;
                chk_vec("r029 slip66", {dd[0], hd[0]}, pat);
            end
        end
        chk_int("r029 slip66 blocks_seen", int'(cnt > 0), 1);
        lk[0] = 1'b0;
        step();

        // 16-bit lane: lock loss at fill 40, then a clean restart.
        lk[2] = 1'b1;
        for (int k = 0; k < 19; k++) begin
            dw[2] = {48'd0, 16'($urandom)};
            step();
        end
        lk[2] = 1'b0;
        step();
        chk_int("r030 valid_after_loss", int'(v[2]), 0);
        lk[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dw[2] = {48'd0, 16'($urandom)};
            cat80[k*16 +: 16] = dw[2][15:0];
            step();
            if (k < 4) chk_int("r030 no_early_block", int'(v[2]), 0);
        end
        chk_int("r030 relock_valid", int'(v[2]), 1);
        chk_vec("r030 relock_block", {dd[2], hd[2]}, cat80[65:0]);
        lk[2] = 1'b0;
        step();

        // Asynchronous reset while a block is being presented.
        lk[0] = 1'b1;
        dw[0] = {$urandom, $urandom};
        step();
        dw[0] = {$urandom, $urandom};
        step();
        chk_int("r031 valid_before_reset", int'(v[0]), 1);
        #3 nreset = 1'b0;
        #1;
        model_reset();
        check_all("r031 async");
        #2 nreset = 1'b1;
        run_027("r031 restart");

        // Slip on the same edge as an extraction (fill 128 -> 127).
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        cat192 = {w2, w1, w0};
        lk[0] = 1'b1;
        dw[0] = w0;
        step();
        dw[0] = w1;
        sl[0] = 1'b1;
        step();
        sl[0] = 1'b0;
        chk_int("r032 valid", int'(v[0]), 1);
        chk_vec("r032 block", {dd[0], hd[0]}, cat192[66:1]);
        dw[0] = w2;
        step();
        chk_int("r032 next_valid", int'(v[0]), 1);
        chk_vec("r032 next_block", {dd[0], hd[0]}, cat192[132:67]);
        lk[0] = 1'b0;
        step();

        // Random lock, slip and data on all lanes.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                lk[i] = ($urandom_range(0, 24) != 0);
                sl[i] = ($urandom_range(0, 9) == 0);
                dw[i] = {$urandom, $urandom};
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
